mem_port_arbiter: RTL and testbench

//  Parametrised successor to the instruction/operand address mux. Arbitrates

---
 rtl/mem_port_arbiter.sv | 138 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Shared memory port arbiter for fetch and data requesters.
// Fixed priority with bounded fetch starvation, or round-robin.
module mem_port_arbiter #(
    parameter int ADDR_WIDTH    = 5,
    parameter int DATA_WIDTH    = 32,
    parameter int PRIORITY_MODE = 0,
    parameter int STARVE_LIMIT  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  inst_req,
    input  logic [ADDR_WIDTH-1:0] inst_addr,
    output logic                  inst_gnt,
    output logic                  inst_rvalid,
    output logic [DATA_WIDTH-1:0] inst_rdata,
    input  logic                  data_req,
    input  logic                  data_we,
    input  logic [ADDR_WIDTH-1:0] data_addr,
    input  logic [DATA_WIDTH-1:0] data_wdata,
    output logic                  data_gnt,
    output logic                  data_rvalid,
    output logic [DATA_WIDTH-1:0] data_rdata,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic                  mem_ready,
    input  logic                  mem_rvalid,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  sel
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT
    } state_t;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    state_t     state;
    state_t     state_nxt;
    logic       sel_nxt;
    logic       rr_last;
    logic [3:0] starve_cnt;
    logic       starved;
    logic       pick_data;
    logic       gnt_fire;
    logic       rsp_fire;

    assign starved  = (STARVE_LIMIT != 0) && (starve_cnt == LIMIT);
    assign gnt_fire = (state == ISSUE) && mem_ready;
    assign rsp_fire = ((state == ISSUE) && mem_ready && mem_rvalid) ||
                      ((state == WAIT) && mem_rvalid);

    // Owner choice when sampled in IDLE; only meaningful with a request.
    always_comb begin
        pick_data = 1'b0;
        if (data_req && !inst_req) begin
            pick_data = 1'b1;
        end else if (data_req && inst_req) begin
            if (PRIORITY_MODE == 1) begin
                pick_data = ~rr_last;
            end else begin
                pick_data = ~starved;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        sel_nxt   = sel;
        unique case (state)
            IDLE: begin
                if (inst_req || data_req) begin
                    sel_nxt   = pick_data;
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                if (mem_ready) begin
                    state_nxt = mem_rvalid ? IDLE : WAIT;
                end
            end
            WAIT: begin
                if (mem_rvalid) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            sel   <= 1'b0;
        end else begin
            state <= state_nxt;
            sel   <= sel_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_last <= 1'b1;
        end else if (gnt_fire) begin
            rr_last <= sel;
        end
    end

    // Counts data wins over a waiting fetch; saturates at the limit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= '0;
        end else if (PRIORITY_MODE == 1) begin
            starve_cnt <= '0;
        end else if (gnt_fire && !sel) begin
            starve_cnt <= '0;
        end else if (state == IDLE && !inst_req) begin
            starve_cnt <= '0;
        end else if (gnt_fire && sel && inst_req && starve_cnt != LIMIT) begin
            starve_cnt <= starve_cnt + 4'd1;
        end
    end

    assign mem_req     = (state == ISSUE);
    assign mem_we      = sel & data_we;
    assign mem_addr    = sel ? data_addr : inst_addr;
    assign mem_wdata   = data_wdata;
    assign inst_gnt    = gnt_fire & ~sel;
    assign data_gnt    = gnt_fire & sel;
    assign inst_rvalid = rsp_fire & ~sel;
    assign data_rvalid = rsp_fire & sel;
    assign inst_rdata  = mem_rdata;
    assign data_rdata  = mem_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: fixed-priority and round-robin
// instances share one set of requester and memory stimulus.
module tb_mem_port_arbiter;

    localparam int AW = 5;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          inst_req;
    logic [AW-1:0] inst_addr;
    logic          data_req;
    logic          data_we;
    logic [AW-1:0] data_addr;
    logic [DW-1:0] data_wdata;
    logic          mem_ready;
    logic          mem_rvalid;
    logic [DW-1:0] mem_rdata;

    logic          f_inst_gnt, f_inst_rvalid, f_data_gnt, f_data_rvalid;
    logic [DW-1:0] f_inst_rdata, f_data_rdata, f_mem_wdata;
    logic          f_mem_req, f_mem_we, f_sel;
    logic [AW-1:0] f_mem_addr;

    logic          r_inst_gnt, r_inst_rvalid, r_data_gnt, r_data_rvalid;
    logic [DW-1:0] r_inst_rdata, r_data_rdata, r_mem_wdata;
    logic          r_mem_req, r_mem_we, r_sel;
    logic [AW-1:0] r_mem_addr;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
        .PRIORITY_MODE(0), .STARVE_LIMIT(4)
    ) u_fix (
        .clk(clk), .rst_n(rst_n),
        .inst_req(inst_req), .inst_addr(inst_addr),
        .inst_gnt(f_inst_gnt), .inst_rvalid(f_inst_rvalid),
        .inst_rdata(f_inst_rdata),
        .data_req(data_req), .data_we(data_we),
        .data_addr(data_addr), .data_wdata(data_wdata),
        .data_gnt(f_data_gnt), .data_rvalid(f_data_rvalid),
        .data_rdata(f_data_rdata),
        .mem_req(f_mem_req), .mem_we(f_mem_we),
        .mem_addr(f_mem_addr), .mem_wdata(f_mem_wdata),
        .mem_ready(mem_ready), .mem_rvalid(mem_rvalid),
        .mem_rdata(mem_rdata), .sel(f_sel)
    );

    mem_port_arbiter #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
        .PRIORITY_MODE(1), .STARVE_LIMIT(4)
    ) u_rr (
        .clk(clk), .rst_n(rst_n),
        .inst_req(inst_req), .inst_addr(inst_addr),
        .inst_gnt(r_inst_gnt), .inst_rvalid(r_inst_rvalid),
        .inst_rdata(r_inst_rdata),
        .data_req(data_req), .data_we(data_we),
        .data_addr(data_addr), .data_wdata(data_wdata),
        .data_gnt(r_data_gnt), .data_rvalid(r_data_rvalid),
        .data_rdata(r_data_rdata),
        .mem_req(r_mem_req), .mem_we(r_mem_we),
        .mem_addr(r_mem_addr), .mem_wdata(r_mem_wdata),
        .mem_ready(mem_ready), .mem_rvalid(mem_rvalid),
        .mem_rdata(mem_rdata), .sel(r_sel)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    initial begin
        string f_seq;
        string r_seq;
        int    f_n;
        int    r_n;

        rst_n      = 1'b0;
        inst_req   = 1'b0;
        inst_addr  = 5'b10000;
        data_req   = 1'b0;
        data_we    = 1'b0;
        data_addr  = 5'b11111;
        data_wdata = 32'h1234_5678;
        mem_ready  = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = '0;

        // Reset state
        step(); #1;
        chk("rst_mem_req", f_mem_req, 0);
        chk("rst_sel", f_sel, 0);
        chk("rst_gnts", {f_inst_gnt, f_data_gnt, r_inst_gnt, r_data_gnt}, 0);
        chk("rst_rvalids", {f_inst_rvalid, f_data_rvalid}, 0);
        chk("rst_mem_addr", f_mem_addr, 5'b10000);
        chk("rst_rr_mem_addr", r_mem_addr, 5'b10000);

        // Lone fetch
        step();
        rst_n     = 1'b1;
        inst_req  = 1'b1;
        mem_ready = 1'b1;
        #1;
        chk("fetch_idle_req", f_mem_req, 0);
        chk("fetch_idle_gnt", f_inst_gnt, 0);
        step(); #1;
        chk("fetch_mem_req", f_mem_req, 1);
        chk("fetch_gnt", {f_inst_gnt, f_data_gnt}, 2'b10);
        chk("fetch_mem_addr", f_mem_addr, 5'b10000);
        chk("fetch_no_rvalid", f_inst_rvalid, 0);
        step();
        inst_req   = 1'b0;
        mem_ready  = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hCAFE_0001;
        #1;
        chk("fetch_wait_req", f_mem_req, 0);
        chk("fetch_rvalid", {f_inst_rvalid, f_data_rvalid}, 2'b10);
        chk("fetch_rdata", f_inst_rdata, 32'hCAFE_0001);
        chk("fetch_rr_rvalid", r_inst_rvalid, 1);
        step();
        #1;
        chk("fetch_idle_ignore", {f_inst_rvalid, r_inst_rvalid}, 0);
        mem_rvalid = 1'b0;

        // Continuous conflict, zero-wait memory; fresh arbitration state
        step();
        rst_n = 1'b0;
        step();
        rst_n      = 1'b1;
        inst_req   = 1'b1;
        data_req   = 1'b1;
        mem_ready  = 1'b1;
        mem_rvalid = 1'b1;
        f_seq = "";
        r_seq = "";
        f_n = 0;
        r_n = 0;
        for (int c = 0; c < 40 && (f_n < 10 || r_n < 10); c++) begin
            step(); #1;
            if (f_n < 10 && f_data_gnt) begin
                f_seq = {f_seq, "D"};
                f_n++;
                chk("fix_addr_D", f_mem_addr, 5'b11111);
            end else if (f_n < 10 && f_inst_gnt) begin
                f_seq = {f_seq, "I"};
                f_n++;
                chk("fix_addr_I", f_mem_addr, 5'b10000);
            end
            if (r_n < 10 && (r_inst_gnt || r_data_gnt)) begin
                r_seq = {r_seq, r_sel ? "D" : "I"};
                r_n++;
            end
        end
        chk("fix_order", (f_seq == "DDDDIDDDDI"), 1);
        if (f_seq != "DDDDIDDDDI")
            $display("fixed order seen: %s", f_seq);
        chk("rr_order", (r_seq == "IDIDIDIDID"), 1);
        if (r_seq != "IDIDIDIDID")
            $display("rr order seen: %s", r_seq);
        chk("rr_grant_count", r_n, 10);

        // Data write with three stall cycles
        step();
        inst_req   = 1'b0;
        data_req   = 1'b0;
        mem_ready  = 1'b0;
        mem_rvalid = 1'b0;
        step();
        data_req   = 1'b1;
        data_we    = 1'b1;
        data_wdata = 32'hA5A5_0F0F;
        for (int k = 0; k < 3; k++) begin
            step(); #1;
            chk("wr_stall_req", f_mem_req, 1);
            chk("wr_stall_addr", f_mem_addr, 5'b11111);
            chk("wr_stall_we", f_mem_we, 1);
            chk("wr_stall_gnt", f_data_gnt, 0);
            chk("wr_stall_sel", f_sel, 1);
        end
        step();
        mem_ready = 1'b1;
        #1;
        chk("wr_ready_req", f_mem_req, 1);
        chk("wr_ready_we", f_mem_we, 1);
        chk("wr_wdata", f_mem_wdata, 32'hA5A5_0F0F);
        chk("wr_gnt", {f_data_gnt, r_data_gnt}, 2'b11);
        chk("wr_no_rvalid", f_data_rvalid, 0);
        step();
        data_req  = 1'b0;
        mem_ready = 1'b0;
        #1;
        chk("wr_wait_req", f_mem_req, 0);
        chk("wr_wait_gnt", f_data_gnt, 0);
        step();
        mem_rvalid = 1'b1;
        #1;
        chk("wr_ack", {f_data_rvalid, f_inst_rvalid}, 2'b10);
        step();
        mem_rvalid = 1'b0;
        data_we    = 1'b0;

        // Reset while waiting on a data read with fetch also pending
        step();
        inst_req  = 1'b1;
        data_req  = 1'b1;
        mem_ready = 1'b1;
        step(); #1;
        chk("rw_data_gnt", f_data_gnt, 1);
        step();
        mem_ready = 1'b0;
        #1;
        chk("rw_wait_req", f_mem_req, 0);
        chk("rw_starve_pre", u_fix.starve_cnt, 1);
        rst_n = 1'b0;
        #1;
        chk("rw_rst_req", f_mem_req, 0);
        chk("rw_rst_sel", f_sel, 0);
        chk("rw_rst_starve", u_fix.starve_cnt, 0);
        step();
        rst_n      = 1'b1;
        inst_req   = 1'b0;
        data_req   = 1'b0;
        mem_rvalid = 1'b1;
        #1;
        chk("rw_ignore_f",
            {f_inst_rvalid, f_data_rvalid, f_inst_gnt, f_data_gnt}, 0);
        chk("rw_ignore_r", {r_inst_rvalid, r_data_rvalid}, 0);
        step(); #1;
        chk("rw_idle_req", f_mem_req, 0);
        chk("rw_idle_rvalid", f_data_rvalid, 0);
        mem_rvalid = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
